// File: rtl/ul8_control_unit.sv
// UL8 fetch/decode/execute sequencer: Moore decode of the state register plus ir.
// Optional build macro UL8_CTRL_JZ_EN turns opcode 000 into JZ (conditional jump on akku_zero).
module ul8_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       akku_zero,
    output logic [2:0] bus_sel,
    output logic       akku_load,
    output logic       pc_load,
    output logic       x_load,
    output logic       y_load,
    output logic       ar_load,
    output logic       ir_load,
    output logic [1:0] alu_op,
    output logic       pc_inc,
    output logic       mem_we,
    output logic       halted
);

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        EXEC0,
        EXEC1,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_STA = 3'b010,
        OP_LDX = 3'b011,
        OP_LDY = 3'b100,
        OP_ALU = 3'b101,
        OP_JMP = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    localparam logic [2:0] BUS_AKKU = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_RAM  = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_ALU  = 3'd6;

    state_t  state;
    state_t  next_state;
    opcode_t opcode;

    // Operand bits reach the datapath directly; only ir[7:5] and ir[1:0] matter here.
    logic unused_inputs;
    assign unused_inputs = ^{ir[4:2], akku_zero};

    assign opcode = opcode_t'(ir[7:5]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH0: next_state = FETCH1;
            FETCH1: next_state = EXEC0;
            EXEC0: begin
                case (opcode)
                    OP_LDA, OP_STA, OP_LDX, OP_LDY, OP_ALU: next_state = EXEC1;
                    OP_HLT:                                 next_state = HALT;
                    default:                                next_state = FETCH0;
                endcase
            end
            EXEC1:   next_state = FETCH0;
            HALT:    next_state = HALT;
            default: next_state = FETCH0;
        endcase
    end

    // rst_n gates the decode so a reset asserted mid-instruction kills every strobe at once.
    always_comb begin
        bus_sel   = '0;
        akku_load = 1'b0;
        pc_load   = 1'b0;
        x_load    = 1'b0;
        y_load    = 1'b0;
        ar_load   = 1'b0;
        ir_load   = 1'b0;
        alu_op    = '0;
        pc_inc    = 1'b0;
        mem_we    = 1'b0;
        halted    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH0: begin
                    bus_sel = BUS_PC;
                    ar_load = 1'b1;
                end
                FETCH1: begin
                    bus_sel = BUS_RAM;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                EXEC0: begin
                    case (opcode)
                        OP_LDA, OP_STA, OP_LDX, OP_LDY: begin
                            bus_sel = BUS_IR;
                            ar_load = 1'b1;
                        end
                        OP_ALU: alu_op = ir[1:0];
                        OP_JMP: begin
                            bus_sel = BUS_IR;
                            pc_load = 1'b1;
                        end
`ifdef UL8_CTRL_JZ_EN
                        OP_NOP: begin
                            if (akku_zero) begin
                                bus_sel = BUS_IR;
                                pc_load = 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                EXEC1: begin
                    case (opcode)
                        OP_LDA: begin
                            bus_sel   = BUS_RAM;
                            akku_load = 1'b1;
                        end
                        OP_STA: begin
                            bus_sel = BUS_AKKU;
                            mem_we  = 1'b1;
                        end
                        OP_LDX: begin
                            bus_sel = BUS_RAM;
                            x_load  = 1'b1;
                        end
                        OP_LDY: begin
                            bus_sel = BUS_RAM;
                            y_load  = 1'b1;
                        end
                        OP_ALU: begin
                            alu_op    = ir[1:0];
                            bus_sel   = BUS_ALU;
                            akku_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
